mbist_march_ctrl: RTL
=====================

# mbist_march_ctrl

Memory BIST controller that runs a March C- test on the team's single-port synchronous memory model (`fault_mem`) and reports pass/fail. It sits between the test top and the memory under test. It drives the memory's `write_read`/`address`/`wdata` inputs and checks `rdata` against expected values through a read-latency-matched compare pipeline.

## Interface
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 4, memory address width
- CAPACITY, 15, highest address tested; N = CAPACITY+1 words, range 0..CAPACITY

- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin test; sampled only in IDLE
- busy  out  1  test in progress
- done  out  1  test finished; held until next accepted start
- fail  out  1  at least one read mismatch occurred
- fail_addr  out  ADDR_WIDTH  address of first mismatching read
- fail_syndrome  out  DATA_WIDTH  rdata XOR expected of first mismatch
- err_count  out  8  number of mismatching reads, saturating at 8'hFF
- mem_write_read  out  1  1 = write, 0 = read
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- March C- elements, in order. 0 = all-zeros word, 1 = all-ones word.
  - M0 ↑(w0)
  - M1 ↑(r0,w1)
  - M2 ↑(r1,w0)
  - M3 ↓(r0,w1)
  - M4 ↓(r1,w0)
  - M5 ↑(r0)
- ↑ walks addresses 0→CAPACITY; ↓ walks addresses CAPACITY→0.
- FSM states: IDLE, SETUP, RUN, DRAIN, DONE.
  - IDLE: on start=1, go to SETUP with element=M0. Set busy, clear done/fail/fail_addr/fail_syndrome/err_count.
  - SETUP: lasts exactly 1 cycle. mem_wdata loads the element's write value (M5 keeps the previous value). mem_write_read=0. mem_address = element start address. Then go to RUN.
  - RUN: M0 issues one write per cycle. M1–M4 issue a read cycle then a write cycle per address, with the address held for both cycles. M5 issues one read per cycle. After the last address, go to SETUP of the next element, or to DRAIN after M5.
  - DRAIN: lasts 2 cycles so outstanding reads are compared. Then go to DONE.
  - DONE: busy=0, done=1. On start=1, restart exactly as from IDLE.
- mem_wdata changes only on entry to SETUP, so it is stable for the memory's one-cycle write-data staging.
- Compare pipeline:
  - Every issued read pushes {valid, address, expected} into a 2-stage shift register.
  - At stage 2, mem_rdata is compared with expected.
  - On mismatch: err_count increments (saturating). On the first mismatch, fail, fail_addr and fail_syndrome latch.
- start while busy is ignored.
- mem_write_read is 0 in all states except write cycles of RUN.

## Timing
- Reset values:
  - busy, done, fail, mem_write_read = 0
  - fail_addr, fail_syndrome, err_count, mem_address, mem_wdata = 0
  - FSM = IDLE; pipeline valids = 0
- Reset asserted mid-test aborts immediately to reset values. No partial result is retained.
- Read latency is 2 cycles: a read issued in cycle t is compared against mem_rdata in cycle t+2.
- Total test length: done (and busy falling) occurs 10N+8 cycles after the edge that samples start. For N=16 this is 168 cycles.
- All outputs are registered.

## Configuration
- MBIST_STOP_ON_FAIL_EN
  - Defined: on the first mismatch the FSM goes directly to DONE on the next edge. mem_write_read=0. fail_addr/fail_syndrome are the first failure. err_count = 1.
  - Undefined: the test always runs to completion in 10N+8 cycles. err_count counts all mismatches.

## Test plan
- Fault-free memory, defaults, start pulse → done after 168 cycles; fail=0, err_count=0; address order and write_read pattern match March C- exactly.
- Memory with addr 6 bit 5 stuck-at-1, macro undefined → fail=1, fail_addr=6, fail_syndrome=8'h20, err_count=3 (M1, M3, M5 r0 reads).
- Same fault, macro defined → done asserted 2 cycles after the M1 read of addr 6 issues; fail_addr=6, fail_syndrome=8'h20, err_count=1.
- rst pulsed during M3 → all outputs return to reset values asynchronously; a following start runs a full clean 168-cycle test.
- start held high during RUN and re-pulsed in DONE → no effect while busy; second run starts from DONE and clears previous results.
- CAPACITY=0 (N=1) → done after 18 cycles; M3/M4 descending walk touches only addr 0.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// ============================================================================
// mbist_march_ctrl : March C- memory BIST controller with a 2-cycle read compare
// Build option: MBIST_STOP_ON_FAIL_EN halts the test on the first mismatch.
// Revision: 1.0
// ============================================================================
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_syndrome,
  output logic [7:0]            err_count,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] c_m0 = 3'd0;
  localparam logic [2:0] c_m1 = 3'd1;
  localparam logic [2:0] c_m2 = 3'd2;
  localparam logic [2:0] c_m3 = 3'd3;
  localparam logic [2:0] c_m4 = 3'd4;
  localparam logic [2:0] c_m5 = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] c_addr_zero = '0;
  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] c_zeros     = '0;
  localparam logic [DATA_WIDTH-1:0] c_ones      = '1;

  state_t                  r_state;
  logic [2:0]              r_elem;
  logic                    r_rd_issue;
  logic                    r_drain;
  logic                    r_p1_valid;
  logic [ADDR_WIDTH-1:0]   r_p1_addr;
  logic [DATA_WIDTH-1:0]   r_p1_exp;
  logic                    r_p2_valid;
  logic [ADDR_WIDTH-1:0]   r_p2_addr;
  logic [DATA_WIDTH-1:0]   r_p2_exp;

  logic [2:0]              w_elem_next;
  logic                    w_desc;
  logic                    w_at_last;
  logic                    w_addr_done;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic                    w_mismatch;
  logic [7:0]              w_err_next;

  function automatic logic elem_desc(input logic [2:0] e);
    return (e == c_m3) || (e == c_m4);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] elem_first(input logic [2:0] e);
    return elem_desc(e) ? c_last_addr : c_addr_zero;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] elem_final(input logic [2:0] e);
    return elem_desc(e) ? c_addr_zero : c_last_addr;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] elem_wval(input logic [2:0] e);
    return ((e == c_m1) || (e == c_m3)) ? c_ones : c_zeros;
  endfunction

  // Value the element's reads expect: what the preceding element left behind.
  function automatic logic [DATA_WIDTH-1:0] elem_exp(input logic [2:0] e);
    return ((e == c_m2) || (e == c_m4)) ? c_ones : c_zeros;
  endfunction

  assign w_elem_next = r_elem + 3'd1;
  assign w_desc      = elem_desc(r_elem);
  assign w_at_last   = (mem_address == elem_final(r_elem));
  assign w_next_addr = w_desc ? (mem_address - c_addr_one) : (mem_address + c_addr_one);
  // An address is finished after its write (M0..M4) or its only read (M5).
  assign w_addr_done = (r_elem == c_m5) || mem_write_read;
  assign w_mismatch  = r_p2_valid && (mem_rdata != r_p2_exp);
  assign w_err_next  = (err_count == 8'hFF) ? 8'hFF : (err_count + 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_elem         <= c_m0;
      r_rd_issue     <= 1'b0;
      r_drain        <= 1'b0;
      r_p1_valid     <= 1'b0;
      r_p1_addr      <= '0;
      r_p1_exp       <= '0;
      r_p2_valid     <= 1'b0;
      r_p2_addr      <= '0;
      r_p2_exp       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_addr      <= '0;
      fail_syndrome  <= '0;
      err_count      <= 8'd0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
    end else begin
      r_p1_valid <= r_rd_issue;
      r_p1_addr  <= mem_address;
      r_p1_exp   <= elem_exp(r_elem);
      r_p2_valid <= r_p1_valid;
      r_p2_addr  <= r_p1_addr;
      r_p2_exp   <= r_p1_exp;

      if (w_mismatch) begin
        err_count <= w_err_next;
        if (!fail) begin
          fail          <= 1'b1;
          fail_addr     <= r_p2_addr;
          fail_syndrome <= mem_rdata ^ r_p2_exp;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state        <= S_SETUP;
            r_elem         <= c_m0;
            r_rd_issue     <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_addr      <= '0;
            fail_syndrome  <= '0;
            err_count      <= 8'd0;
            mem_write_read <= 1'b0;
            mem_address    <= elem_first(c_m0);
            mem_wdata      <= elem_wval(c_m0);
          end
        end

        S_SETUP: begin
          r_state        <= S_RUN;
          mem_write_read <= (r_elem == c_m0);
          r_rd_issue     <= (r_elem != c_m0);
        end

        S_RUN: begin
          if (w_addr_done) begin
            if (w_at_last) begin
              mem_write_read <= 1'b0;
              r_rd_issue     <= 1'b0;
              if (r_elem == c_m5) begin
                r_state <= S_DRAIN;
                r_drain <= 1'b0;
              end else begin
                r_state     <= S_SETUP;
                r_elem      <= w_elem_next;
                mem_address <= elem_first(w_elem_next);
                if (w_elem_next != c_m5) begin
                  mem_wdata <= elem_wval(w_elem_next);
                end
              end
            end else begin
              mem_address    <= w_next_addr;
              mem_write_read <= (r_elem == c_m0);
              r_rd_issue     <= (r_elem != c_m0);
            end
          end else begin
            mem_write_read <= 1'b1;
            r_rd_issue     <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

`ifdef MBIST_STOP_ON_FAIL_EN
      // Abort on the first mismatch and flush younger reads so only it is counted.
      if (w_mismatch) begin
        r_state        <= S_DONE;
        busy           <= 1'b0;
        done           <= 1'b1;
        mem_write_read <= 1'b0;
        r_rd_issue     <= 1'b0;
        r_p1_valid     <= 1'b0;
        r_p2_valid     <= 1'b0;
      end
`else
`endif
    end
  end

endmodule
`default_nettype wire
